// File: rtl/mmio_master.sv
// Initiator for the memory-mapped peripheral bus: one LSU request at a time,
// decoded to a device slot, single-cycle device access, registered response.
module mmio_master #(
  parameter int unsigned          XLEN      = 64,
  parameter int unsigned          NDEV      = 4,
  parameter logic [XLEN-1:0]      MMIO_BASE = XLEN'(64'h0200_0000),
  parameter int unsigned          SLOT_BITS = 12
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [XLEN-1:0]        req_addr,
  input  logic [XLEN-1:0]        req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [XLEN-1:0]        rsp_rdata,
  output logic                   rsp_error,
  output logic [NDEV-1:0]        dev_cen,
  output logic                   dev_wr,
  output logic [SLOT_BITS-1:0]   dev_addr,
  output logic [XLEN-1:0]        dev_wdata,
  input  logic [NDEV*XLEN-1:0]   dev_rdata,
  input  logic [NDEV-1:0]        dev_error
);

  localparam int unsigned SW = $clog2(NDEV);
  localparam int unsigned AB = $clog2(XLEN / 8);
  localparam logic [XLEN-1:0] WINDOW = XLEN'(NDEV) << SLOT_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t          state;
  logic [SW-1:0]   slot_q;

  logic [XLEN-1:0] offset;
  logic            in_window;
  logic            misaligned;
  logic            dec_ok;
  logic [SW-1:0]   dec_slot;
  logic [NDEV-1:0] dec_onehot;
  logic [XLEN-1:0] sel_rdata;
  logic            sel_error;

  // Unsigned subtraction folds "below base" into the same compare as "above window".
  always_comb begin
    offset     = req_addr - MMIO_BASE;
    in_window  = offset < WINDOW;
    misaligned = |req_addr[AB-1:0];
    dec_ok     = in_window && !misaligned;
    dec_slot   = req_addr[SLOT_BITS +: SW];
    dec_onehot = NDEV'(1) << dec_slot;
  end

  always_comb begin
    sel_rdata = '0;
    sel_error = 1'b0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (slot_q == SW'(i)) begin
        sel_rdata = dev_rdata[i*XLEN +: XLEN];
        sel_error = dev_error[i];
      end
    end
  end

  // dev_* registers double as the request latch; they are only non-zero in ACCESS.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      slot_q    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      dev_cen   <= '0;
      dev_wr    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (dec_ok) begin
              state     <= ACCESS;
              slot_q    <= dec_slot;
              dev_cen   <= dec_onehot;
              dev_wr    <= req_wr;
              dev_addr  <= req_addr[SLOT_BITS-1:0];
              dev_wdata <= req_wdata;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_error <= 1'b1;
            end
          end
        end
        ACCESS: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= dev_wr ? '0 : sel_rdata;
          rsp_error <= sel_error;
          dev_cen   <= '0;
          dev_wr    <= 1'b0;
          dev_addr  <= '0;
          dev_wdata <= '0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          dev_cen   <= '0;
          dev_wr    <= 1'b0;
          dev_addr  <= '0;
          dev_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_master.sv
// Directed bench for mmio_master: vector table of single transactions plus
// hand sequences for response back-pressure and reset during an access.
module tb_mmio_master;

  localparam logic [63:0] B  = 64'h0200_0000;
  localparam logic [63:0] D0 = 64'h0000_0000_0000_1234;
  localparam logic [63:0] D1 = 64'h5555_0000_0000_0001;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_0000_0002;
  localparam logic [63:0] D3 = 64'h0000_0000_0000_3333;

  logic         clk;
  logic         rstn;
  logic         req_valid;
  logic         req_ready;
  logic         req_wr;
  logic [63:0]  req_addr;
  logic [63:0]  req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_rdata;
  logic         rsp_error;
  logic [3:0]   dev_cen;
  logic         dev_wr;
  logic [11:0]  dev_addr;
  logic [63:0]  dev_wdata;
  logic [255:0] dev_rdata;
  logic [3:0]   dev_error;

  // Slot 3 behaves like the timer: it faults on any write.
  assign dev_rdata = {D3, D2, D1, D0};
  assign dev_error = {dev_wr, 3'b000};

  mmio_master #(
    .XLEN(64),
    .NDEV(4),
    .MMIO_BASE(64'h0200_0000),
    .SLOT_BITS(12)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .dev_cen(dev_cen),
    .dev_wr(dev_wr),
    .dev_addr(dev_addr),
    .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata),
    .dev_error(dev_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        acc;
    logic [3:0]  cen;
    logic [11:0] daddr;
    logic        err;
    logic [63:0] rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, B,                  64'h0,    1'b1, 4'b0001, 12'h000, 1'b0, D0};
    vecs[1] = '{1'b1, B + 64'h1008,       64'hAA,   1'b1, 4'b0010, 12'h008, 1'b0, 64'h0};
    vecs[2] = '{1'b0, B + 64'h2010,       64'hF00D, 1'b1, 4'b0100, 12'h010, 1'b0, D2};
    vecs[3] = '{1'b0, B + 64'h3FF8,       64'h0,    1'b1, 4'b1000, 12'hFF8, 1'b0, D3};
    vecs[4] = '{1'b1, B + 64'h3000,       64'h77,   1'b1, 4'b1000, 12'h000, 1'b1, 64'h0};
    vecs[5] = '{1'b0, B + 64'h4000,       64'h0,    1'b0, 4'b0000, 12'h000, 1'b1, 64'h0};
    vecs[6] = '{1'b0, 64'h0000_0000_01FF_FFF8, 64'h0, 1'b0, 4'b0000, 12'h000, 1'b1, 64'h0};
    vecs[7] = '{1'b0, B + 64'h3,          64'h0,    1'b0, 4'b0000, 12'h000, 1'b1, 64'h0};
    vecs[8] = '{1'b1, B + 64'h1004,       64'h55,   1'b0, 4'b0000, 12'h000, 1'b1, 64'h0};
    vecs[9] = '{1'b0, 64'h0,              64'h0,    1'b0, 4'b0000, 12'h000, 1'b1, 64'h0};

    rstn      = 1'b0;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    #12;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", rsp_rdata, 64'd0);
    chk("reset rsp_error", 64'(rsp_error), 64'd0);
    chk("reset dev_cen",   64'(dev_cen), 64'd0);
    chk("reset dev_wr",    64'(dev_wr), 64'd0);
    chk("reset dev_addr",  64'(dev_addr), 64'd0);
    chk("reset dev_wdata", dev_wdata, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      // cycle T: present the request
      req_valid = 1'b1;
      req_wr    = vecs[i].wr;
      req_addr  = vecs[i].addr;
      req_wdata = vecs[i].wdata;
      chk($sformatf("v%0d req_ready T", i), 64'(req_ready), 64'd1);
      @(negedge clk);
      // cycle T+1
      req_valid = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      if (vecs[i].acc) begin
        chk($sformatf("v%0d dev_cen", i),   64'(dev_cen), 64'(vecs[i].cen));
        chk($sformatf("v%0d dev_wr", i),    64'(dev_wr), 64'(vecs[i].wr));
        chk($sformatf("v%0d dev_addr", i),  64'(dev_addr), 64'(vecs[i].daddr));
        chk($sformatf("v%0d dev_wdata", i), dev_wdata, vecs[i].wdata);
        chk($sformatf("v%0d rsp_valid T1", i), 64'(rsp_valid), 64'd0);
        @(negedge clk);
        // cycle T+2
        chk($sformatf("v%0d dev_cen off", i), 64'(dev_cen), 64'd0);
      end else begin
        chk($sformatf("v%0d no dev_cen", i), 64'(dev_cen), 64'd0);
      end
      chk($sformatf("v%0d rsp_valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("v%0d rsp_error", i), 64'(rsp_error), 64'(vecs[i].err));
      chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].rdata);
      chk($sformatf("v%0d req_ready busy", i), 64'(req_ready), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d req_ready back", i), 64'(req_ready), 64'd1);
      chk($sformatf("v%0d rsp_valid off", i), 64'(rsp_valid), 64'd0);
    end

    // Back-pressure: response held 5 cycles while a second request waits.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = B + 64'h1000;
    @(negedge clk);
    req_addr  = B;
    chk("bp dev_cen", 64'(dev_cen), 64'b0010);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d rsp_valid", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp%0d rsp_rdata", k), rsp_rdata, D1);
      chk($sformatf("bp%0d rsp_error", k), 64'(rsp_error), 64'd0);
      chk($sformatf("bp%0d req_ready", k), 64'(req_ready), 64'd0);
      chk($sformatf("bp%0d dev_cen", k), 64'(dev_cen), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp retire rsp_valid", 64'(rsp_valid), 64'd0);
    chk("bp retire req_ready", 64'(req_ready), 64'd1);
    chk("bp retire dev_cen", 64'(dev_cen), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp second dev_cen", 64'(dev_cen), 64'b0001);
    @(negedge clk);
    chk("bp second rsp_valid", 64'(rsp_valid), 64'd1);
    chk("bp second rsp_rdata", rsp_rdata, D0);
    @(negedge clk);
    chk("bp second done", 64'(req_ready), 64'd1);

    // Reset asserted in the middle of ACCESS.
    req_valid = 1'b1;
    req_addr  = B + 64'h2000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst pre dev_cen", 64'(dev_cen), 64'b0100);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst async dev_cen", 64'(dev_cen), 64'd0);
    chk("rst async req_ready", 64'(req_ready), 64'd1);
    chk("rst async rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst post%0d rsp_valid", k), 64'(rsp_valid), 64'd0);
      chk($sformatf("rst post%0d req_ready", k), 64'(req_ready), 64'd1);
      chk($sformatf("rst post%0d dev_cen", k), 64'(dev_cen), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mmio_master.md
# mmio_master

Initiator side of the simple peripheral bus used by the memory-mapped devices (timer, etc.). It accepts one load/store request at a time from the core's LSU over a valid/ready handshake and decodes the address to one of `NDEV` device slots. It drives a single-cycle `cen`/`wr` access to the selected device, captures that device's combinational `rdata`/`error`, and returns a response over a second valid/ready handshake. Out-of-window or misaligned addresses are rejected without touching any device.

## Interface
Parameters:
- `XLEN`, default 64: data and address width; tracks the `XLEN` define.
- `NDEV`, default 4: number of device slots; power of two, at least 2.
- `MMIO_BASE`, default 64'h0200_0000: base of the MMIO window; aligned to the window size.
- `SLOT_BITS`, default 12: log2 of the bytes per device slot.

Ports:
- `clk`  in  1: the only clock.
- `rstn`  in  1: reset; asynchronous assert, active-low.
- `req_valid`  in  1: LSU request valid.
- `req_ready`  out  1: master can accept a request.
- `req_wr`  in  1: 1 = store, 0 = load.
- `req_addr`  in  XLEN: byte address.
- `req_wdata`  in  XLEN: store data.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: LSU accepts the response.
- `rsp_rdata`  out  XLEN: load data; 0 for stores and for errors.
- `rsp_error`  out  1: access fault.
- `dev_cen`  out  NDEV: one-hot device select.
- `dev_wr`  out  1: write strobe, shared by all devices.
- `dev_addr`  out  SLOT_BITS: offset within the slot.
- `dev_wdata`  out  XLEN: write data, shared by all devices.
- `dev_rdata`  in  NDEV*XLEN: device read data; slot i occupies bits [i*XLEN +: XLEN].
- `dev_error`  in  NDEV: device error, one bit per slot.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `wr`, `addr` and `wdata`, then decode.
- Decode:
  - In-window means `(req_addr - MMIO_BASE) < NDEV << SLOT_BITS`, computed unsigned at XLEN width.
  - Slot = `req_addr[SLOT_BITS +: log2(NDEV)]`.
  - Misaligned means `req_addr[log2(XLEN/8)-1:0] != 0`.
  - If in-window and aligned, go to ACCESS.
  - Otherwise load the decode error (`rsp_error`=1, `rsp_rdata`=0) and go directly to RESP.
- ACCESS, exactly one cycle:
  - `dev_cen[slot]`=1; all other `dev_cen` bits 0.
  - `dev_wr`, `dev_addr` and `dev_wdata` come from the latched request.
  - At the end of the cycle, register `rsp_rdata` = `dev_rdata[slot]` for loads and 0 for stores.
  - At the end of the cycle, register `rsp_error` = `dev_error[slot]`.
  - Next state is RESP.
- RESP:
  - `rsp_valid`=1, and `rsp_rdata`/`rsp_error` hold stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- `req_ready`=0 in ACCESS and RESP. A new request is never accepted in the same cycle a response retires.
- Outside ACCESS: `dev_cen`=0, `dev_wr`=0, `dev_addr`=0, `dev_wdata`=0.
- A device error on a store is reported, and the store has no further effect in this block.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0, `dev_cen`=0, `dev_wr`=0, `dev_addr`=0, `dev_wdata`=0.
- If `rstn` falls mid-transaction, all state clears immediately. Any in-flight request is dropped without a response, and `dev_cen` deasserts asynchronously.

## Timing
- Request handshake in cycle T with a valid address:
  - `dev_cen` high in cycle T+1 only.
  - `rsp_valid` rises at T+2.
  - With `rsp_ready` held high, `req_ready` is back at T+3.
- Decode error:
  - `rsp_valid` rises at T+1 and no `dev_cen` pulse occurs.
  - `req_ready` is back at T+2 if `rsp_ready`=1.
- Throughput is 1 transaction per 3 cycles for a device access and 1 per 2 cycles for a decode error.
- `rsp_*` are registered outputs. `req_ready` and `dev_*` are decoded from state and registers only, with no combinational path from `req_*` or `rsp_ready` to any output.
- `dev_rdata`/`dev_error` are sampled only at the ACCESS clock edge. A device that returns its counter value returns the value present in the ACCESS cycle.

## Test plan
- Load from slot 0 (`MMIO_BASE`+0) with device 0 rdata = 64'h1234, error 0, and `rsp_ready`=1:
  - `dev_cen`=4'b0001 and `dev_wr`=0 for 1 cycle at T+1.
  - `rsp_valid` at T+2 with `rsp_rdata`=64'h1234 and `rsp_error`=0.
- Store to `MMIO_BASE`+0x1008 with data 64'hAA:
  - `dev_cen`=4'b0010, `dev_addr`=12'h008, `dev_wdata`=64'hAA, `dev_wr`=1.
  - Store to a device that asserts error for writes (as the timer does): `rsp_error`=1 and `rsp_rdata`=0.
- Out-of-window addresses:
  - `MMIO_BASE`+0x4000: `dev_cen` stays 0, `rsp_valid` at T+1, `rsp_error`=1.
  - `MMIO_BASE`-8: same response.
- Misaligned load at `MMIO_BASE`+0x3: no device access, `rsp_error`=1.
- Hold `rsp_ready`=0 for 5 cycles:
  - `rsp_valid` and data stay stable and `req_ready` stays 0.
  - A `req_valid` asserted during the hold is not accepted until the cycle after the response handshake.
- Pull `rstn` low during ACCESS:
  - `dev_cen` drops without waiting for a clock edge.
  - After release: `req_ready`=1, `rsp_valid`=0, and no stale response appears.
